multdiv: RTL and testbench



---
 rtl/multdiv_pkg.sv | 24 ++
 rtl/multdiv_if.sv | 23 ++
 rtl/adder.sv | 12 +
 rtl/negate32.sv | 10 +
 rtl/multdiv.sv | 161 ++++++++++++++++
 tb/tb_multdiv.sv | 216 +++++++++++++++++++++
 6 files changed

// File: rtl/multdiv_pkg.sv
// Shared types and constants for the multicycle multiply/divide unit.
// Optional divide datapath is selected by the MULTDIV_DIV_EN macro.
package multdiv_pkg;

  localparam int unsigned MULTDIV_W     = 32;
  localparam int unsigned MULTDIV_ITERS = 32;
  localparam int unsigned MULTDIV_CNT_W = $clog2(MULTDIV_ITERS);

  localparam logic [MULTDIV_W-1:0] MULTDIV_INT_MIN = 32'h8000_0000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MULT,
    ST_DIV,
    ST_DONE
  } multdiv_state_e;

  // Result payload returned to the pipeline with the ready pulse
  typedef struct packed {
    logic [MULTDIV_W-1:0] result;
    logic                 exception;
  } multdiv_resp_t;

endpackage

// File: rtl/multdiv_if.sv
// Operand/control/result bundle between the execute stage and multdiv.
interface multdiv_if;
  import multdiv_pkg::*;

  logic [MULTDIV_W-1:0] data_operandA;
  logic [MULTDIV_W-1:0] data_operandB;
  logic                 ctrl_MULT;
  logic                 ctrl_DIV;
  logic [MULTDIV_W-1:0] data_result;
  logic                 data_exception;
  logic                 data_resultRDY;

  modport master (
    output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
    input  data_result, data_exception, data_resultRDY
  );

  modport slave (
    input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
    output data_result, data_exception, data_resultRDY
  );

endinterface

// File: rtl/adder.sv
// 32-bit adder with carry in/out, shared by iterative datapaths.
module adder (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);

  assign {cout, sum} = 33'(a) + 33'(b) + 33'(cin);

endmodule

// File: rtl/negate32.sv
// Conditional two's-complement negate; with en = sign bit it yields |value|.
module negate32 (
  input  logic [31:0] value,
  input  logic        en,
  output logic [31:0] result
);

  assign result = en ? (~value + 32'd1) : value;

endmodule

// File: rtl/multdiv.sv
// Multicycle signed multiply / restoring divide, 33-cycle start-to-ready latency.
// Define MULTDIV_DIV_EN to build the divide datapath; otherwise divide reports an exception.
module multdiv
  import multdiv_pkg::*;
(
  input  logic      clock,
  input  logic      reset,
  multdiv_if.slave  bus
);

  multdiv_state_e           state_q, state_d;
  logic [MULTDIV_CNT_W-1:0] cnt_q;
  logic [MULTDIV_W-1:0]     acc_hi_q, acc_lo_q, bmag_q;
  logic                     neg_q, op_div_q, rdy_q;
  multdiv_resp_t            resp_q, resp_d;

  logic                 start_c, start_div_c, iter_c, done_c, last_c;
  logic [MULTDIV_W-1:0] amag_c, bmag_c, lo_fix_c, hi_neg_c, hi_fix_c;
  logic                 lo_zero_c;
  logic [MULTDIV_W-1:0] add_a_c, add_b_c, sum_c, step_hi_c, step_lo_c;
  logic                 add_cin_c, cout_c;
`ifdef MULTDIV_DIV_EN
  logic                 bzero_q;
  logic [MULTDIV_W-1:0] rem_shift_c;
`endif

  assign start_c     = bus.ctrl_MULT | bus.ctrl_DIV;
  assign start_div_c = bus.ctrl_DIV & ~bus.ctrl_MULT;
  assign last_c      = (cnt_q == MULTDIV_CNT_W'(MULTDIV_ITERS - 1));
  assign done_c      = (state_q == ST_DONE);

  // State register
  always_ff @(posedge clock) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next state; a start pulse overrides whatever the current op was doing
  always_comb begin
    state_d = state_q;
    iter_c  = 1'b0;
    case (state_q)
      ST_MULT, ST_DIV: begin
        iter_c = 1'b1;
        if (last_c) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = state_q;
    endcase
    if (start_c) begin
`ifdef MULTDIV_DIV_EN
      state_d = start_div_c ? ST_DIV : ST_MULT;
`else
      state_d = start_div_c ? ST_DONE : ST_MULT;
`endif
    end
  end

  negate32 u_abs_a (.value(bus.data_operandA), .en(bus.data_operandA[MULTDIV_W-1]), .result(amag_c));
  negate32 u_abs_b (.value(bus.data_operandB), .en(bus.data_operandB[MULTDIV_W-1]), .result(bmag_c));

  // Sign fix of the 64-bit accumulator: low word negates, high word carries only if low is zero
  assign lo_zero_c = (acc_lo_q == '0);
  negate32 u_fix_lo (.value(acc_lo_q), .en(neg_q), .result(lo_fix_c));
  negate32 u_fix_hi (.value(acc_hi_q), .en(neg_q & lo_zero_c), .result(hi_neg_c));
  assign hi_fix_c = (neg_q & ~lo_zero_c) ? ~acc_hi_q : hi_neg_c;

`ifdef MULTDIV_DIV_EN
  assign rem_shift_c = {acc_hi_q[MULTDIV_W-2:0], acc_lo_q[MULTDIV_W-1]};
`endif

  // Adder operands: multiplicand add, or trial subtract of the divisor
  always_comb begin
    add_a_c   = acc_hi_q;
    add_b_c   = bmag_q;
    add_cin_c = 1'b0;
`ifdef MULTDIV_DIV_EN
    if (op_div_q) begin
      add_a_c   = rem_shift_c;
      add_b_c   = ~bmag_q;
      add_cin_c = 1'b1;
    end
`endif
  end

  adder u_adder (.a(add_a_c), .b(add_b_c), .cin(add_cin_c), .sum(sum_c), .cout(cout_c));

  // One iteration of shift-add multiply or restoring divide
  always_comb begin
    step_hi_c = {1'b0, acc_hi_q[MULTDIV_W-1:1]};
    step_lo_c = {acc_hi_q[0], acc_lo_q[MULTDIV_W-1:1]};
    if (acc_lo_q[0]) begin
      step_hi_c = {cout_c, sum_c[MULTDIV_W-1:1]};
      step_lo_c = {sum_c[0], acc_lo_q[MULTDIV_W-1:1]};
    end
`ifdef MULTDIV_DIV_EN
    if (op_div_q) begin
      step_hi_c = cout_c ? sum_c : rem_shift_c;
      step_lo_c = {acc_lo_q[MULTDIV_W-2:0], cout_c};
    end
`endif
  end

  // Final result and exception from the signed accumulator
  always_comb begin
    resp_d.result    = lo_fix_c;
    resp_d.exception = (hi_fix_c != {MULTDIV_W{lo_fix_c[MULTDIV_W-1]}});
    if (op_div_q) begin
`ifdef MULTDIV_DIV_EN
      if (bzero_q) begin
        resp_d.result    = '0;
        resp_d.exception = 1'b1;
      end else begin
        resp_d.exception = (acc_lo_q == MULTDIV_INT_MIN) & ~neg_q;
      end
`else
      resp_d.result    = '0;
      resp_d.exception = 1'b1;
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q    <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      bmag_q   <= '0;
      neg_q    <= 1'b0;
      op_div_q <= 1'b0;
      rdy_q    <= 1'b0;
      resp_q   <= '0;
`ifdef MULTDIV_DIV_EN
      bzero_q  <= 1'b0;
`endif
    end else begin
      rdy_q <= done_c;
      if (done_c) resp_q <= resp_d;
      if (start_c) begin
        cnt_q    <= '0;
        acc_hi_q <= '0;
        acc_lo_q <= amag_c;
        bmag_q   <= bmag_c;
        neg_q    <= bus.data_operandA[MULTDIV_W-1] ^ bus.data_operandB[MULTDIV_W-1];
        op_div_q <= start_div_c;
`ifdef MULTDIV_DIV_EN
        bzero_q  <= (bus.data_operandB == '0);
`endif
      end else if (iter_c) begin
        cnt_q    <= cnt_q + MULTDIV_CNT_W'(1);
        acc_hi_q <= step_hi_c;
        acc_lo_q <= step_lo_c;
      end
    end
  end

  assign bus.data_result    = resp_q.result;
  assign bus.data_exception = resp_q.exception;
  assign bus.data_resultRDY = rdy_q;

endmodule

// File: tb/tb_multdiv.sv
// Self-checking bench for multdiv: directed test-plan cases plus randomized ops
// checked against a plain-arithmetic reference model.
module tb_multdiv;

  logic clock = 1'b0;
  logic reset;
  multdiv_if bus ();

  multdiv dut (.clock(clock), .reset(reset), .bus(bus));

  always #5 clock = ~clock;

  int vectors     = 0;
  int miscompares = 0;

  bit          dir_div [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  logic [31:0] dir_a   [5] = '{32'd7, 32'h0001_0000, 32'hFFFF_FF9C, 32'h8000_0000, 32'd5};
  logic [31:0] dir_b   [5] = '{32'hFFFF_FFFA, 32'h0001_0000, 32'd7, 32'hFFFF_FFFF, 32'd0};

  // Reference: signed 64-bit product, or truncating signed quotient with special cases
  function automatic void model(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic e);
    longint p;
    int     sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    if (!is_div) begin
      p = longint'(sa) * longint'(sb);
      r = p[31:0];
      e = (p != longint'($signed(r)));
    end else begin
`ifdef MULTDIV_DIV_EN
      if (b == 32'd0) begin
        r = 32'd0; e = 1'b1;
      end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        r = 32'h8000_0000; e = 1'b1;
      end else begin
        r = 32'(sa / sb); e = 1'b0;
      end
`else
      r = 32'd0; e = 1'b1;
`endif
    end
  endfunction

  function automatic int exp_lat(input bit is_div);
`ifdef MULTDIV_DIV_EN
    return 33;
`else
    return is_div ? 1 : 33;
`endif
  endfunction

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 200)) - 32'd100;
      default: return 32'($urandom);
    endcase
  endfunction

  // Pulse start for one edge, then scramble operands so late sampling is visible
  task automatic start_op(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b);
    bus.data_operandA = a;
    bus.data_operandB = b;
    bus.ctrl_MULT     = m;
    bus.ctrl_DIV      = d;
    @(posedge clock); #1;
    bus.ctrl_MULT     = 1'b0;
    bus.ctrl_DIV      = 1'b0;
    bus.data_operandA = 32'($urandom);
    bus.data_operandB = 32'($urandom);
  endtask

  task automatic wait_rdy(input int budget, output int lat, output bit seen);
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < budget) begin
      @(posedge clock); #1;
      lat++;
      if (bus.data_resultRDY === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic count_rdy(input int n, output int hits);
    hits = 0;
    repeat (n) begin
      @(posedge clock); #1;
      if (bus.data_resultRDY !== 1'b0) hits++;
    end
  endtask

  task automatic test_reset();
    int hits;
    reset = 1'b1;
    bus.ctrl_MULT = 1'b1;
    bus.data_operandA = 32'd3;
    bus.data_operandB = 32'd3;
    repeat (3) @(posedge clock);
    #1;
    bus.ctrl_MULT = 1'b0;
    vectors++; if (bus.data_result !== 32'd0) begin miscompares++; $display("FAIL reset_result: got %h want 0", bus.data_result); end
    vectors++; if (bus.data_exception !== 1'b0) begin miscompares++; $display("FAIL reset_exception: got %b want 0", bus.data_exception); end
    vectors++; if (bus.data_resultRDY !== 1'b0) begin miscompares++; $display("FAIL reset_rdy: got %b want 0", bus.data_resultRDY); end
    reset = 1'b0;
    count_rdy(40, hits);
    vectors++; if (hits !== 0) begin miscompares++; $display("FAIL reset_beats_start: got %0d rdy pulses want 0", hits); end
  endtask

  task automatic test_directed();
    int lat; bit seen; logic [31:0] er; logic ee;
    for (int i = 0; i < 5; i++) begin
      model(dir_div[i], dir_a[i], dir_b[i], er, ee);
      start_op(!dir_div[i], dir_div[i], dir_a[i], dir_b[i]);
      wait_rdy(60, lat, seen);
      vectors++; if (!seen || lat != exp_lat(dir_div[i])) begin miscompares++; $display("FAIL dir%0d_latency: got %0d (seen %b) want %0d", i, lat, seen, exp_lat(dir_div[i])); end
      vectors++; if (bus.data_result !== er) begin miscompares++; $display("FAIL dir%0d_result: got %h want %h", i, bus.data_result, er); end
      vectors++; if (bus.data_exception !== ee) begin miscompares++; $display("FAIL dir%0d_exception: got %b want %b", i, bus.data_exception, ee); end
      @(posedge clock); #1;
      vectors++; if (bus.data_resultRDY !== 1'b0 || bus.data_result !== er) begin miscompares++; $display("FAIL dir%0d_pulse_hold: got rdy %b result %h want rdy 0 result %h", i, bus.data_resultRDY, bus.data_result, er); end
    end
  endtask

  task automatic test_random();
    int lat; bit seen; logic [31:0] a, b, er; logic ee; bit d;
    for (int i = 0; i < 24; i++) begin
      d = 1'($urandom_range(0, 1));
      a = rand_operand();
      b = rand_operand();
      model(d, a, b, er, ee);
      start_op(!d, d, a, b);
      wait_rdy(60, lat, seen);
      vectors++; if (!seen || lat != exp_lat(d)) begin miscompares++; $display("FAIL rnd%0d_latency: got %0d (seen %b) want %0d", i, lat, seen, exp_lat(d)); end
      vectors++; if (bus.data_result !== er || bus.data_exception !== ee) begin miscompares++; $display("FAIL rnd%0d_%s %h %h: got %h/%b want %h/%b", i, d ? "div" : "mul", a, b, bus.data_result, bus.data_exception, er, ee); end
    end
  endtask

  task automatic test_simultaneous();
    int lat; bit seen; logic [31:0] er; logic ee;
    model(1'b0, 32'hFFFF_FFF9, 32'd9, er, ee);
    start_op(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd9);
    wait_rdy(60, lat, seen);
    vectors++; if (!seen || lat != 33) begin miscompares++; $display("FAIL both_latency: got %0d (seen %b) want 33", lat, seen); end
    vectors++; if (bus.data_result !== er || bus.data_exception !== ee) begin miscompares++; $display("FAIL both_mult_wins: got %h/%b want %h/%b", bus.data_result, bus.data_exception, er, ee); end
  endtask

  task automatic test_abort();
    int lat, hits; bit seen; logic [31:0] er; logic ee;
    model(1'b1, 32'd20, 32'd3, er, ee);
    start_op(1'b1, 1'b0, 32'd3, 32'd4);
    count_rdy(9, hits);
    vectors++; if (hits !== 0) begin miscompares++; $display("FAIL abort_early_rdy: got %0d pulses want 0", hits); end
    start_op(1'b0, 1'b1, 32'd20, 32'd3);
    wait_rdy(60, lat, seen);
    vectors++; if (!seen || lat != exp_lat(1'b1)) begin miscompares++; $display("FAIL abort_latency: got %0d (seen %b) want %0d", lat, seen, exp_lat(1'b1)); end
    vectors++; if (bus.data_result !== er || bus.data_exception !== ee) begin miscompares++; $display("FAIL abort_result: got %h/%b want %h/%b", bus.data_result, bus.data_exception, er, ee); end
    count_rdy(40, hits);
    vectors++; if (hits !== 0) begin miscompares++; $display("FAIL abort_stray_rdy: got %0d pulses want 0", hits); end
  endtask

  task automatic test_reset_mid();
    int lat, hits; bit seen; logic [31:0] er; logic ee;
    start_op(1'b1, 1'b0, 32'd9, 32'd9);
    repeat (14) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    count_rdy(40, hits);
    vectors++; if (hits !== 0) begin miscompares++; $display("FAIL rstmid_rdy: got %0d pulses want 0", hits); end
    vectors++; if (bus.data_result !== 32'd0 || bus.data_exception !== 1'b0) begin miscompares++; $display("FAIL rstmid_outputs: got %h/%b want 0/0", bus.data_result, bus.data_exception); end
    model(1'b0, 32'd2, 32'd2, er, ee);
    start_op(1'b1, 1'b0, 32'd2, 32'd2);
    wait_rdy(60, lat, seen);
    vectors++; if (!seen || lat != 33 || bus.data_result !== er || bus.data_exception !== ee) begin miscompares++; $display("FAIL rstmid_fresh: got lat %0d %h/%b want lat 33 %h/%b", lat, bus.data_result, bus.data_exception, er, ee); end
  endtask

  // New start lands on the DONE cycle: old op still reports, new op follows
  task automatic test_back_to_back();
    int lat; bit seen, d2; logic [31:0] a1, b1, a2, b2, r1, r2; logic e1, e2;
    for (int i = 0; i < 3; i++) begin
      a1 = rand_operand(); b1 = rand_operand();
      a2 = rand_operand(); b2 = rand_operand();
      d2 = 1'($urandom_range(0, 1));
      model(1'b0, a1, b1, r1, e1);
      model(d2, a2, b2, r2, e2);
      start_op(1'b1, 1'b0, a1, b1);
      repeat (32) @(posedge clock);
      #1;
      start_op(!d2, d2, a2, b2);
      vectors++; if (bus.data_resultRDY !== 1'b1 || bus.data_result !== r1 || bus.data_exception !== e1) begin miscompares++; $display("FAIL b2b%0d_first: got rdy %b %h/%b want rdy 1 %h/%b", i, bus.data_resultRDY, bus.data_result, bus.data_exception, r1, e1); end
      wait_rdy(60, lat, seen);
      vectors++; if (!seen || lat != exp_lat(d2) || bus.data_result !== r2 || bus.data_exception !== e2) begin miscompares++; $display("FAIL b2b%0d_second: got lat %0d %h/%b want lat %0d %h/%b", i, lat, bus.data_result, bus.data_exception, exp_lat(d2), r2, e2); end
    end
  endtask

  initial begin
    bus.data_operandA = 32'd0;
    bus.data_operandB = 32'd0;
    bus.ctrl_MULT     = 1'b0;
    bus.ctrl_DIV      = 1'b0;
    reset             = 1'b1;
    test_reset();
    test_directed();
    test_random();
    test_simultaneous();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
